// File: rtl/framebuffer_writer_pkg.sv
// rtl/framebuffer_writer_pkg.sv - shared defaults, pixel/write types and FSM encoding for the framebuffer writer
package framebuffer_writer_pkg;

  localparam int DEF_SCREEN_W   = 320;
  localparam int DEF_SCREEN_H   = 240;
  localparam int DEF_RGB_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ADDR_WIDTH = 20;

  typedef struct packed {
    logic [DEF_RGB_WIDTH-1:0] r;
    logic [DEF_RGB_WIDTH-1:0] g;
    logic [DEF_RGB_WIDTH-1:0] b;
  } color_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    color_t                    data;
  } fb_write_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } fb_state_t;

endpackage

// File: rtl/framebuffer_writer_if.sv
// rtl/framebuffer_writer_if.sv - valid/ready framebuffer memory write port
interface framebuffer_writer_if
  import framebuffer_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = 3 * DEF_RGB_WIDTH
) ();

  logic                  mem_wr_valid;
  logic                  mem_wr_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport master (
    output mem_wr_valid,
    output mem_wr_addr,
    output mem_wr_data,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_valid,
    input  mem_wr_addr,
    input  mem_wr_data,
    output mem_wr_ready
  );

endinterface

// File: rtl/framebuffer_writer_pixel_fifo.sv
// rtl/framebuffer_writer_pixel_fifo.sv - show-ahead synchronous FIFO holding {addr,color} entries
module framebuffer_writer_pixel_fifo
  import framebuffer_writer_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_WIDTH + 3 * DEF_RGB_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - raster address generation, pixel buffering and registered framebuffer write port
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int RGB_WIDTH  = DEF_RGB_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [3*RGB_WIDTH-1:0] color_in,
  input  logic                   color_valid,
  framebuffer_writer_if.master   mem_wr,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int DATA_W  = 3 * RGB_WIDTH;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_W;
  localparam int XW      = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW      = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  fb_state_t state;
  fb_state_t state_nxt;

  logic [XW-1:0]         x_cnt;
  logic [YW-1:0]         y_cnt;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  last_pixel;
  logic                  start_frame;
  logic                  accept_pixel;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_dout;

  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_W-1:0]     out_data;

  assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (frame_start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (color_valid && last_pixel) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (fifo_empty && !out_valid) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_busy   = 1'b0;
    frame_done   = 1'b0;
    start_frame  = 1'b0;
    accept_pixel = 1'b0;
    unique case (state)
      ST_IDLE:   start_frame = frame_start;
      ST_ACTIVE: begin
        frame_busy   = 1'b1;
        accept_pixel = color_valid;
      end
      ST_FLUSH:  frame_busy = 1'b1;
      ST_DONE:   frame_done = 1'b1;
      default:   frame_busy = 1'b0;
    endcase
  end

  // A full FIFO still takes a pixel when the output stage drains its head in the same cycle.
  assign fifo_pop  = !fifo_empty && (!out_valid || mem_wr.mem_wr_ready);
  assign fifo_push = accept_pixel && (!fifo_full || fifo_pop);

  // Raster position and address advance on dropped pixels too, so later pixels land correctly.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      pix_addr <= '0;
      overflow <= 1'b0;
    end else if (start_frame) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      pix_addr <= base_addr;
      overflow <= 1'b0;
    end else if (accept_pixel) begin
      pix_addr <= pix_addr + 1'b1;
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
      if (!fifo_push) overflow <= 1'b1;
    end
  end

  framebuffer_writer_pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({pix_addr, color_in}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (fifo_pop) begin
      out_valid <= 1'b1;
      out_addr  <= fifo_dout[ENTRY_W-1:DATA_W];
      out_data  <= fifo_dout[DATA_W-1:0];
    end else if (mem_wr.mem_wr_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign mem_wr.mem_wr_valid = out_valid;
  assign mem_wr.mem_wr_addr  = out_addr;
  assign mem_wr.mem_wr_data  = out_data;

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - directed and randomized bench for framebuffer_writer against a frame-level model
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int AW = 20;

  localparam int P_IDLE   = 0;
  localparam int P_ACTIVE = 1;
  localparam int P_FLUSH  = 2;
  localparam int P_DONE   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [AW-1:0] base_addr;
  logic [23:0]   color_in;
  logic          color_valid;
  logic          frame_busy;
  logic          frame_done;
  logic          overflow;

  framebuffer_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(24)) mem_wr ();

  framebuffer_writer #(
    .SCREEN_W   (W),
    .SCREEN_H   (H),
    .RGB_WIDTH  (8),
    .FIFO_DEPTH (D),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .color_in    (color_in),
    .color_valid (color_valid),
    .mem_wr      (mem_wr.master),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int last_hs_cyc = 0;

  fb_write_t wlog[$];

  // Frame-level model: pending writes queue, output slot, frame phase and pixel index.
  fb_write_t     m_fifo[$];
  logic          m_sv    = 1'b0;
  fb_write_t     m_st;
  int            m_phase = P_IDLE;
  int            m_n     = 0;
  logic [AW-1:0] m_base  = '0;
  logic          m_ovf   = 1'b0;
  logic          m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst_i, input logic fs_i, input logic [AW-1:0] base_i,
                      input logic cv_i, input logic [23:0] col_i, input logic rdy_i);
    logic      wr, pop, push, flush_ok;
    fb_write_t e;
    if (m_known) begin
      check("mem_wr_valid", 32'(mem_wr.mem_wr_valid), 32'(m_sv));
      if (m_sv) begin
        check("mem_wr_addr", 32'(mem_wr.mem_wr_addr), 32'(m_st.addr));
        check("mem_wr_data", 32'(mem_wr.mem_wr_data), 32'(m_st.data));
      end
      check("frame_busy", 32'(frame_busy), 32'(m_phase == P_ACTIVE || m_phase == P_FLUSH));
      check("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (!rst_i && mem_wr.mem_wr_valid === 1'b1 && rdy_i) begin
      wlog.push_back({mem_wr.mem_wr_addr, mem_wr.mem_wr_data});
      last_hs_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    reset               = rst_i;
    frame_start         = fs_i;
    base_addr           = base_i;
    color_valid         = cv_i;
    color_in            = col_i;
    mem_wr.mem_wr_ready = rdy_i;
    if (rst_i) begin
      m_fifo.delete();
      m_sv    = 1'b0;
      m_phase = P_IDLE;
      m_n     = 0;
      m_ovf   = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      wr       = m_sv && rdy_i;
      pop      = (m_fifo.size() > 0) && (!m_sv || rdy_i);
      push     = (m_phase == P_ACTIVE) && cv_i && ((m_fifo.size() < D) || pop);
      flush_ok = (m_fifo.size() == 0) && !m_sv;
      e.addr   = m_base + AW'((m_n / W) * W + (m_n % W));
      e.data   = col_i;
      if (pop) begin
        m_st = m_fifo.pop_front();
        m_sv = 1'b1;
      end else if (wr) begin
        m_sv = 1'b0;
      end
      if (push) m_fifo.push_back(e);
      case (m_phase)
        P_IDLE: if (fs_i) begin
          m_phase = P_ACTIVE;
          m_base  = base_i;
          m_n     = 0;
          m_ovf   = 1'b0;
        end
        P_ACTIVE: if (cv_i) begin
          if (!push) m_ovf = 1'b1;
          m_n++;
          if (m_n == W * H) m_phase = P_FLUSH;
        end
        P_FLUSH: if (flush_ok) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic rdy);
    step(1'b0, 1'b1, b, 1'b0, 24'($urandom), rdy);
  endtask

  task automatic pixel(input logic [23:0] col, input logic rdy);
    step(1'b0, 1'b0, AW'($urandom), 1'b1, col, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, AW'($urandom), 1'b0, 24'($urandom), rdy);
  endtask

  // rdy_mode 0/1: constant ready, 2: random ready that settles high.
  task automatic drain(input int rdy_mode);
    int   d0;
    logic r;
    d0 = done_cnt;
    for (int i = 0; i < 80 && done_cnt == d0; i++) begin
      if (rdy_mode == 2) r = (i > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      else               r = (rdy_mode != 0);
      idle(r);
    end
    check("frame_done_seen", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic check_log(input string tag, input logic [AW-1:0] b, input int n,
                           input logic [23:0] cols [8]);
    fb_write_t e;
    check({tag, "_count"}, 32'(wlog.size()), 32'(n));
    for (int j = 0; j < n && j < wlog.size(); j++) begin
      e = wlog[j];
      check({tag, "_addr"}, 32'(e.addr), 32'(b + AW'(j)));
      check({tag, "_data"}, 32'(e.data), 32'(cols[j]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] cols [8];
    int          d0;
    int          limit;

    reset               = 1'b1;
    frame_start         = 1'b0;
    base_addr           = '0;
    color_in            = '0;
    color_valid         = 1'b0;
    mem_wr.mem_wr_ready = 1'b0;
    @(negedge clk);

    // Reset with random inputs, then idle pixels must be ignored.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), AW'($urandom), 1'($urandom), 24'($urandom), 1'($urandom));
    check("rst_valid", 32'(mem_wr.mem_wr_valid), 32'd0);
    check("rst_addr", 32'(mem_wr.mem_wr_addr), 32'd0);
    check("rst_data", 32'(mem_wr.mem_wr_data), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    wlog.delete();
    for (int i = 0; i < 4; i++) pixel(24'($urandom), 1'b1);
    idle(1'b1);
    check("idle_no_write", 32'(wlog.size()), 32'd0);

    // Nominal frame.
    for (int i = 0; i < 8; i++) cols[i] = {8'(i), 8'(2 * i), 8'(3 * i)};
    wlog.delete();
    d0 = done_cnt;
    start(20'h100, 1'b1);
    for (int i = 0; i < 8; i++) pixel(cols[i], 1'b1);
    drain(1);
    check_log("nominal", 20'h100, 8, cols);
    check("nominal_done_gap", 32'(done_cyc - last_hs_cyc), 32'd2);
    check("nominal_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("nominal_done_once", 32'(done_cnt), 32'(d0 + 1));

    // Backpressure: only FIFO_DEPTH+1 pixels survive.
    wlog.delete();
    start(20'h100, 1'b0);
    for (int i = 0; i < 8; i++) pixel(cols[i], 1'b0);
    drain(1);
    check_log("bp", 20'h100, 5, cols);
    check("bp_ovf", 32'(overflow), 32'd1);

    // Stall hold with ready 1,0,0,1 including a push into a full FIFO with a pop.
    for (int i = 0; i < 8; i++) cols[i] = 24'($urandom);
    wlog.delete();
    start(20'h100, 1'b1);
    for (int i = 0; i < 8; i++) pixel(cols[i], (i % 4 == 0) || (i % 4 == 3));
    drain(1);
    check_log("stall", 20'h100, 8, cols);
    check("stall_ovf", 32'(overflow), 32'd0);

    // Second frame_start mid-frame is ignored; the next real frame uses it.
    wlog.delete();
    start(20'h100, 1'b0);
    for (int i = 0; i < 3; i++) pixel(cols[i], 1'b0);
    step(1'b0, 1'b1, 20'h200, 1'b1, cols[3], 1'b0);
    for (int i = 4; i < 8; i++) pixel(cols[i], 1'b0);
    drain(1);
    check_log("ign", 20'h100, 5, cols);
    check("ign_ovf", 32'(overflow), 32'd1);
    wlog.delete();
    start(20'h200, 1'b1);
    check("new_frame_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pixel(cols[i], 1'b1);
    drain(1);
    check_log("base200", 20'h200, 8, cols);

    // Reset mid-frame abandons the frame silently.
    d0 = done_cnt;
    start(20'h300, 1'b1);
    for (int i = 0; i < 3; i++) pixel(cols[i], 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    wlog.delete();
    start(20'h300, 1'b1);
    for (int i = 0; i < 8; i++) pixel(cols[i], 1'b1);
    drain(1);
    check_log("after_rst", 20'h300, 8, cols);

    // Randomized frames: sparse pixels, random ready, stray frame_start pulses.
    for (int f = 0; f < 4; f++) begin
      start(AW'($urandom_range(0, 20'hFFFF0)), 1'($urandom));
      limit = 0;
      while (m_phase == P_ACTIVE && limit < 200) begin
        step(1'b0, $urandom_range(0, 9) == 0, AW'($urandom), $urandom_range(0, 2) != 0,
             24'($urandom), 1'($urandom));
        limit++;
      end
      check("rand_frame_complete", 32'(m_phase != P_ACTIVE), 32'd1);
      drain(2);
      for (int i = 0; i < 2; i++) idle(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Sits directly downstream of the Lambertian shading stage.
- Consumes one shaded Color per valid_out pulse, in raster order.
- Assigns each pixel its framebuffer address and buffers it in a small FIFO, because the shader has no backpressure.
- Drains the FIFO to the framebuffer memory over a valid/ready write port, and signals frame completion to the frame controller.

Parameters:
- SCREEN_W, 320, pixels per row.
- SCREEN_H, 240, rows per frame.
- RGB_WIDTH, 8, bits per colour channel (matches Color in Types.sv).
- FIFO_DEPTH, 8, entries in the pixel FIFO; power of two, at least 2.
- ADDR_WIDTH, 20, framebuffer word-address width; must hold base_addr + SCREEN_W*SCREEN_H - 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; arms a new frame (honoured in IDLE only).
- base_addr  in  ADDR_WIDTH  framebuffer base address; sampled on an accepted frame_start.
- color_in  in  3*RGB_WIDTH  Color struct {r,g,b} from the shader.
- color_valid  in  1  color_in is valid this cycle; no ready is returned.
- mem_wr_valid  out  1  write request valid.
- mem_wr_ready  in  1  memory accepts the write this cycle.
- mem_wr_addr  out  ADDR_WIDTH  write address.
- mem_wr_data  out  3*RGB_WIDTH  packed {r,g,b}, r in the MSBs.
- frame_busy  out  1  high from an accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse when every pixel of the frame has been either written or dropped.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full; cleared on an accepted frame_start.

Behaviour:
- Reset values: mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, frame_busy=0, frame_done=0, overflow=0. FIFO is emptied, counters are zeroed, FSM goes to IDLE. Reset mid-frame abandons the frame with no frame_done.
- FSM states: IDLE, ACTIVE, FLUSH, DONE.
- IDLE:
  - frame_start -> latch base_addr, clear x/y counters and overflow, set frame_busy, go to ACTIVE.
  - color_valid in IDLE is ignored; nothing is written and no flag is set.
- ACTIVE:
  - Each color_valid is one pixel at the current (x,y).
  - Address = latched base + y*SCREEN_W + x. Compute it incrementally with a running index counter; no multiplier.
  - If the FIFO is not full, or a pop happens in the same cycle, push {addr,color}.
  - Otherwise drop the pixel and set overflow.
  - x/y advance on every color_valid, dropped pixels included, so later pixels keep their correct addresses.
  - x wraps from SCREEN_W-1 to 0 and y increments.
  - On the pixel at (SCREEN_W-1, SCREEN_H-1), go to FLUSH.
  - frame_start in ACTIVE or FLUSH is ignored.
- FLUSH:
  - color_valid is ignored.
  - When the FIFO is empty and no write is pending (mem_wr_valid=0), go to DONE.
- DONE: frame_done=1 for exactly one cycle, frame_busy drops in the same cycle, go to IDLE.
- Write port:
  - mem_wr_valid/addr/data form a registered output stage fed from the FIFO head.
  - Once asserted, addr and data are held stable until the cycle mem_wr_ready=1.
  - The next entry loads on that same cycle, so back-to-back writes reach 1 per cycle.
- Latency:
  - A pixel accepted at edge k into an empty FIFO with the output stage free appears on mem_wr_valid after edge k+1.
  - Effective capacity is FIFO_DEPTH + 1 (FIFO plus output stage).
- Simultaneous push and pop with the FIFO full: both happen and nothing is dropped.
- frame_done fires even if pixels were dropped; overflow remains readable until the next accepted frame_start.
- Pointer wrap: pointers use an extra MSB to tell full from empty.

Decomposition:
- Types.sv: add FB_write_t {addr, Color data}.
- Parameters.sv: SCREEN_W and SCREEN_H constants.
- Sub-module pixel_fifo: synchronous FIFO with push, pop, full, empty, and parameters WIDTH and DEPTH. The top level holds the FSM, raster counters and output stage.

Test Plan:
All scenarios use SCREEN_W=4, SCREEN_H=2, FIFO_DEPTH=4.
- Reset: hold reset 3 cycles with random inputs -> all outputs 0, frame_busy=0; color_valid while IDLE -> no mem_wr_valid.
- Nominal: frame_start with base_addr=0x100, mem_wr_ready=1, 8 back-to-back pixels r=i, g=2i, b=3i -> writes to addr 0x100..0x107 in order with data {i,2i,3i}; frame_done pulses once, 1 cycle after the last write handshake; overflow=0.
- Backpressure: mem_wr_ready=0 during 8 back-to-back pixels, then 1 -> writes only 0x100..0x104 (5 = DEPTH+1) with correct data; overflow=1; frame_done after the 5th write.
- Stall hold: ready toggling 1,0,0,1 mid-stream -> addr/data stable while valid && !ready; no write duplicated or skipped.
- Ignored start: a second frame_start with base 0x200 mid-frame -> all addresses still 0x10x; a subsequent frame after frame_done uses 0x200 and clears overflow.
- Mid-frame reset: reset after 3 pixels, then a new frame -> no frame_done for the aborted frame; new frame writes base+0..7 cleanly.
